cnn_layer_scheduler: RTL and testbench

Frame-level sequencer for the CNN accelerator. It launches the layer engines (conv, pool, conv, pool, fc) one at a time over start/done handshakes and guards each layer with a watchdog. It also reduces the streamed fc scores to an argmax class index. It sits between the top-level control and the layer engines, and drives the 4-bit `class` result seen at the CNN top.

---
 rtl/cnn_layer_scheduler.sv | 171 +++++++++++++++++
 tb/tb_cnn_layer_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_scheduler.sv
// Frame sequencer for the CNN layer engines: one start/done handshake per layer,
// a per-layer watchdog, and a streaming argmax over the fc scores.
module cnn_layer_scheduler #(
  parameter int NUM_LAYERS  = 5,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter int CLASS_W     = 4,
  parameter int TIMEOUT     = 100000
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      frame_start,
  output logic [NUM_LAYERS-1:0]     layer_start,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score_in,
  output logic [CLASS_W-1:0]        class_idx,
  output logic                      class_valid,
  output logic                      busy,
  output logic                      error
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_W = $clog2(NUM_CLASSES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CLASSES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                     state_reg;
  logic [IDX_W-1:0]           idx_reg;
  logic [WD_W-1:0]            wd_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       ovf_reg;
  logic signed [SCORE_W-1:0]  best_reg;
  logic [CLASS_W-1:0]         best_idx_reg;

  logic [CNT_W-1:0]           cnt_next;
  logic                       ovf_next;
  logic signed [SCORE_W-1:0]  best_next;
  logic [CLASS_W-1:0]         best_idx_next;

  logic [IDX_W-1:0]           idx_succ;
  logic [NUM_LAYERS-1:0]      idx_onehot;
  logic [NUM_LAYERS-1:0]      succ_onehot;
  logic                       done_hit;
  logic                       beat_accept;
  logic                       frame_ok;

  assign idx_succ = idx_reg + IDX_W'(1);

  // Explicit decoders keep the done select and start pulse in range for
  // non-power-of-two layer counts.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_dec
      assign idx_onehot[gi]  = (idx_reg  == IDX_W'(gi));
      assign succ_onehot[gi] = (idx_succ == IDX_W'(gi));
    end
  endgenerate

  assign done_hit    = |(layer_done & idx_onehot);
  assign beat_accept = (state_reg == S_WAIT) && (idx_reg == LAST_IDX) && score_valid;

  // Next-value argmax so a beat landing with the final done is included.
  always_comb begin
    cnt_next      = cnt_reg;
    ovf_next      = ovf_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    if (beat_accept) begin
      if (cnt_reg == CNT_FULL) begin
        ovf_next = 1'b1;
      end else begin
        if ((cnt_reg == '0) || (score_in > best_reg)) begin
          best_next     = score_in;
          best_idx_next = CLASS_W'(cnt_reg);
        end
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  assign frame_ok = (cnt_next == CNT_FULL) && !ovf_next;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      wd_reg       <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      layer_start  <= '0;
      class_idx    <= '0;
      class_valid  <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      layer_start  <= '0;
      class_valid  <= 1'b0;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;

      case (state_reg)
        S_IDLE, S_ERR: begin
          if (frame_start) begin
            idx_reg     <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            layer_start <= NUM_LAYERS'(1);
            busy        <= 1'b1;
            error       <= 1'b0;
            state_reg   <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          wd_reg    <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (done_hit) begin
            if (idx_reg != LAST_IDX) begin
              idx_reg     <= idx_succ;
              layer_start <= succ_onehot;
              state_reg   <= S_LAUNCH;
            end else if (frame_ok) begin
              class_idx   <= best_idx_next;
              class_valid <= 1'b1;
              state_reg   <= S_DONE;
            end else begin
              error     <= 1'b1;
              busy      <= 1'b0;
              state_reg <= S_ERR;
            end
          end else if (wd_reg == WD_MAX) begin
            error     <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_ERR;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end

        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Bench for cnn_layer_scheduler: emulates the layer engines cycle by cycle and
// predicts sequencing, watchdog and argmax outcome from the frame description.
module tb_cnn_layer_scheduler;

  localparam int NL = 5;
  localparam int NC = 10;
  localparam int SW = 16;
  localparam int CW = 4;
  localparam int TO = 16;

  logic                 clk_in = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 frame_start = 1'b0;
  logic [NL-1:0]        layer_start;
  logic [NL-1:0]        layer_done = '0;
  logic                 score_valid = 1'b0;
  logic signed [SW-1:0] score_in = '0;
  logic [CW-1:0]        class_idx;
  logic                 class_valid;
  logic                 busy;
  logic                 error;

  int tests_run = 0;
  int tests_failed = 0;

  // Frame description consumed by run_frame.
  int dly[NL];
  int sc[$];
  int beat_off;
  bit noise;
  int hang_layer;
  int abort_beats;
  int prev_class = 0;

  cnn_layer_scheduler #(
    .NUM_LAYERS(NL), .NUM_CLASSES(NC), .SCORE_W(SW), .CLASS_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .frame_start(frame_start),
    .layer_start(layer_start), .layer_done(layer_done),
    .score_valid(score_valid), .score_in(score_in),
    .class_idx(class_idx), .class_valid(class_valid), .busy(busy), .error(error)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // First index holding the maximum value.
  function automatic int ref_argmax(input int q[$]);
    int b = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] > q[b]) b = i;
    return b;
  endfunction

  task automatic set_defaults();
    for (int i = 0; i < NL; i++) dly[i] = 3;
    sc.delete();
    beat_off = 0;
    noise = 0;
    hang_layer = -1;
    abort_beats = -1;
  endtask

  task automatic clear_inputs();
    frame_start = 1'b0;
    layer_done = '0;
    score_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    int n;
    bit ok;
    int exp_cls;
    int j;
    n = sc.size();
    ok = (n == NC);
    exp_cls = ok ? ref_argmax(sc) : prev_class;

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s err_clear: got %b want 0", tag, error);
    end

    for (int l = 0; l < NL; l++) begin
      tests_run++;
      if (layer_start !== NL'(1 << l) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s start%0d: got start=%b busy=%b want start=%b busy=1",
                 tag, l, layer_start, busy, NL'(1 << l));
      end
      if (noise) begin
        score_valid = 1'b1;
        score_in = SW'($urandom);
      end
      tick();

      if (l == hang_layer) begin
        for (int d = 1; d <= TO; d++) begin
          clear_inputs();
          if (noise) begin
            layer_done = NL'($urandom) & ~NL'(1 << l);
            frame_start = 1'($urandom_range(0, 1));
          end
          tests_run++;
          if (layer_start !== '0 || error !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s hang_wait%0d: got start=%b err=%b busy=%b want 0/0/1",
                     tag, d, layer_start, error, busy);
          end
          tick();
        end
        clear_inputs();
        tests_run++;
        if (error !== 1'b1 || busy !== 1'b0 || layer_start !== '0 ||
            class_valid !== 1'b0 || class_idx !== CW'(prev_class)) begin
          tests_failed++;
          $display("FAIL %s timeout_err: got err=%b busy=%b start=%b cv=%b class=%0d want 1/0/0/0/%0d",
                   tag, error, busy, layer_start, class_valid, class_idx, prev_class);
        end
        tick();
        tests_run++;
        if (error !== 1'b1 || layer_start !== '0) begin
          tests_failed++;
          $display("FAIL %s err_sticky: got err=%b start=%b want 1/0", tag, error, layer_start);
        end
        $display("[TB] frame %s: timeout at layer %0d, class=%0d", tag, l, class_idx);
        return;
      end

      for (int d = 1; d <= dly[l]; d++) begin
        clear_inputs();
        if (noise) begin
          layer_done = NL'($urandom) & ~NL'(1 << l);
          frame_start = 1'($urandom_range(0, 1));
          if (l < NL - 1) begin
            score_valid = 1'($urandom_range(0, 1));
            score_in = SW'($urandom);
          end
        end
        if (l == NL - 1) begin
          j = d - 1 - beat_off;
          if (abort_beats >= 0 && j == abort_beats) begin
            clear_inputs();
            #2 rst_n = 1'b0;
            #1;
            tests_run++;
            if (layer_start !== '0 || class_idx !== '0 || class_valid !== 1'b0 ||
                busy !== 1'b0 || error !== 1'b0) begin
              tests_failed++;
              $display("FAIL %s async_reset: got start=%b class=%0d cv=%b busy=%b err=%b want all 0",
                       tag, layer_start, class_idx, class_valid, busy, error);
            end
            tick();
            rst_n = 1'b1;
            tick();
            tests_run++;
            if (busy !== 1'b0 || layer_start !== '0 || class_valid !== 1'b0) begin
              tests_failed++;
              $display("FAIL %s post_reset_idle: got busy=%b start=%b cv=%b want 0",
                       tag, busy, layer_start, class_valid);
            end
            prev_class = 0;
            $display("[TB] frame %s: reset after %0d beats", tag, abort_beats);
            return;
          end
          if (j >= 0 && j < n) begin
            score_valid = 1'b1;
            score_in = SW'(sc[j]);
          end
        end
        if (d == dly[l]) layer_done[l] = 1'b1;
        tests_run++;
        if (layer_start !== '0 || busy !== 1'b1 || error !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s wait%0d_%0d: got start=%b busy=%b err=%b want 0/1/0",
                   tag, l, d, layer_start, busy, error);
        end
        tick();
      end
      clear_inputs();
    end

    if (ok) begin
      tests_run++;
      if (class_valid !== 1'b1 || class_idx !== CW'(exp_cls) || busy !== 1'b1 ||
          error !== 1'b0 || layer_start !== '0) begin
        tests_failed++;
        $display("FAIL %s result: got cv=%b class=%0d busy=%b err=%b want 1/%0d/1/0",
                 tag, class_valid, class_idx, busy, error, exp_cls);
      end
      tick();
      tests_run++;
      if (class_valid !== 1'b0 || busy !== 1'b0 || class_idx !== CW'(exp_cls)) begin
        tests_failed++;
        $display("FAIL %s after_done: got cv=%b busy=%b class=%0d want 0/0/%0d",
                 tag, class_valid, busy, class_idx, exp_cls);
      end
      prev_class = exp_cls;
    end else begin
      tests_run++;
      if (error !== 1'b1 || busy !== 1'b0 || class_valid !== 1'b0 ||
          class_idx !== CW'(prev_class)) begin
        tests_failed++;
        $display("FAIL %s count_err: got err=%b busy=%b cv=%b class=%0d want 1/0/0/%0d",
                 tag, error, busy, class_valid, class_idx, prev_class);
      end
    end
    $display("[TB] frame %s: beats=%0d class=%0d err=%b", tag, n, class_idx, error);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    tests_run++;
    if (layer_start !== '0 || class_idx !== '0 || class_valid !== 1'b0 ||
        busy !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got start=%b class=%0d cv=%b busy=%b err=%b want all 0",
               layer_start, class_idx, class_valid, busy, error);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || layer_start !== '0) begin
      tests_failed++;
      $display("FAIL idle_hold: got busy=%b start=%b want 0", busy, layer_start);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_nominal();
    set_defaults();
    dly[NL-1] = NC;
    sc = '{5, -2, 40, 7, 40, 0, -100, 3, 39, 1};
    run_frame("nominal");
    tests_run++;
    if (class_idx !== 4'd2) begin
      tests_failed++;
      $display("FAIL nominal_tie: got class=%0d want 2", class_idx);
    end
  endtask

  task automatic test_back_to_back();
    set_defaults();
    for (int i = 0; i < NL - 1; i++) dly[i] = 1;
    dly[NL-1] = NC;
    sc = '{-3, -9, -1, -4, -1, -8, -2, -5, -6, -7};
    run_frame("b2b_1");
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    run_frame("b2b_2");
  endtask

  task automatic test_timeout();
    set_defaults();
    hang_layer = 2;
    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("timeout");
    set_defaults();
    dly[NL-1] = 12;
    beat_off = 2;
    sc = '{0, 1, 2, 3, 4, 50, 6, 7, 8, 9};
    run_frame("recover");
  endtask

  task automatic test_watchdog_edge();
    set_defaults();
    for (int i = 0; i < NL; i++) dly[i] = TO;
    beat_off = TO - NC;
    sc = '{-5, -6, -7, -8, -9, -10, -11, -12, -13, -4};
    run_frame("wd_edge");
  endtask

  task automatic test_score_count();
    set_defaults();
    dly[NL-1] = 12;
    sc = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    run_frame("beats9");
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    dly[NL-1] = 11;
    run_frame("beats11");
  endtask

  task automatic test_spurious();
    set_defaults();
    noise = 1;
    dly[NL-1] = 11;
    beat_off = 1;
    sc = '{3, 3, 12, 3, -30, 12, 11, 0, 0, 4};
    run_frame("spurious");
  endtask

  task automatic test_random_frames();
    int n;
    int sel;
    for (int f = 0; f < 10; f++) begin
      set_defaults();
      noise = 1'($urandom_range(0, 1));
      for (int i = 0; i < NL - 1; i++) dly[i] = $urandom_range(1, TO);
      sel = $urandom_range(0, 4);
      n = (sel == 0) ? NC - 1 : (sel == 1) ? NC + 1 : NC;
      beat_off = $urandom_range(0, 2);
      dly[NL-1] = beat_off + n + $urandom_range(0, 2);
      if (dly[NL-1] > TO) dly[NL-1] = TO;
      for (int k = 0; k < n; k++) sc.push_back($urandom_range(0, 40) - 20);
      run_frame($sformatf("rand%0d", f));
    end
  endtask

  task automatic test_reset_mid_wait();
    set_defaults();
    dly[NL-1] = NC;
    sc = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0};
    run_frame("pre_reset");
    set_defaults();
    dly[NL-1] = 12;
    abort_beats = 6;
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    run_frame("abort");
    set_defaults();
    dly[NL-1] = NC;
    sc = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
    run_frame("fresh");
    tests_run++;
    if (class_idx !== 4'd0) begin
      tests_failed++;
      $display("FAIL all_equal_class: got class=%0d want 0", class_idx);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_timeout();
    test_watchdog_edge();
    test_score_count();
    test_spurious();
    test_random_frames();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
